weight_read_sequencer: RTL

Controller for one neuron's weight memory. It accepts the neuron's input activation stream, issues the matching weight read address each cycle, and presents aligned (activation, weight) pairs to the neuron MAC. It flags the last pair of each frame so the MAC can add bias and activate. Optionally it also sequences a runtime reload of the weight memory from a configuration stream.

---
 rtl/weight_read_sequencer.sv | 143 ++++++++++++++
 1 files changed

// File: rtl/weight_read_sequencer.sv
// weight_read_sequencer: pairs one neuron's activation stream with its weights.
// Each accepted activation issues a weight read in the same cycle. One cycle
// later the activation and the returned weight are presented together as a
// pair, and the final pair of each frame is flagged.
// Optional feature macro WEIGHT_LOAD_EN enables the LOAD state, which reloads
// the weight memory from the cfg stream. Without it the cfg port is ignored,
// the write port is tied off, and the memory acts as a ROM.
//
// Handshakes: a word moves on a port only in a cycle where valid && ready are
// both high. in_ready and cfg_ready are decoded from state (cfg_ready also
// depends on in_valid in IDLE) and never depend on anything downstream. If an
// activation and a cfg word are offered together in IDLE, the activation wins.
// A cfg word offered in IDLE while in_valid is low is accepted as word 0 of the
// reload. pair_* has no backpressure.
module weight_read_sequencer #(
  parameter int NUM_WEIGHT = 30,
  parameter int ADDR_W     = $clog2(NUM_WEIGHT),
  parameter int DATA_W     = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  input  logic [DATA_W-1:0] in_data,
  output logic              in_ready,
  output logic              mem_ren,
  output logic [ADDR_W-1:0] mem_radd,
  input  logic [DATA_W-1:0] mem_wout,
  output logic              mem_wen,
  output logic [ADDR_W-1:0] mem_wadd,
  output logic [DATA_W-1:0] mem_win,
  input  logic              cfg_valid,
  input  logic [DATA_W-1:0] cfg_data,
  output logic              cfg_ready,
  output logic              pair_valid,
  output logic [DATA_W-1:0] pair_x,
  output logic [DATA_W-1:0] pair_w,
  output logic              pair_last,
  output logic              load_done,
  output logic              busy
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    DRAIN = 2'd2,
    LOAD  = 2'd3
  } state_t;

  localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(NUM_WEIGHT - 1);

  state_t            state;
  logic [ADDR_W-1:0] rd_cnt;
  logic [ADDR_W-1:0] radd_q;      // last issued read address, held while idle
  logic              accept;
  logic              load_start;  // IDLE leaves for LOAD
  logic              load_finish; // final reload word accepted this cycle

  // Read side: the read issues in the accept cycle; the weight comes back next cycle.
  assign in_ready = (state == IDLE) || (state == RUN);
  assign accept   = in_valid && in_ready;
  assign mem_ren  = accept;
  assign mem_radd = accept ? rd_cnt : radd_q;
  assign pair_w   = pair_valid ? mem_wout : '0;
  assign busy     = (state != IDLE);

`ifdef WEIGHT_LOAD_EN
  logic [ADDR_W-1:0] wr_cnt;
  logic              cfg_accept;

  assign cfg_ready   = ((state == IDLE) && !in_valid) || (state == LOAD);
  assign cfg_accept  = cfg_valid && cfg_ready;
  assign load_start  = cfg_valid;
  assign load_finish = cfg_accept && (wr_cnt == LAST_ADDR);

  // Reload write port: one registered write per accepted cfg word.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_cnt    <= '0;
      mem_wen   <= 1'b0;
      mem_wadd  <= '0;
      mem_win   <= '0;
      load_done <= 1'b0;
    end else begin
      mem_wen   <= cfg_accept;
      load_done <= load_finish;
      if (cfg_accept) begin
        mem_wadd <= wr_cnt;
        mem_win  <= cfg_data;
        wr_cnt   <= load_finish ? '0 : wr_cnt + ADDR_W'(1);
      end
    end
  end
`else
  logic unused_cfg;

  assign unused_cfg  = ^{cfg_valid, cfg_data};
  assign cfg_ready   = 1'b0;
  assign load_start  = 1'b0;
  assign load_finish = 1'b0;
  assign mem_wen     = 1'b0;
  assign mem_wadd    = '0;
  assign mem_win     = '0;
  assign load_done   = 1'b0;
`endif

  // Sequencer FSM with the registered pair outputs and the read address counter.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= IDLE;
      rd_cnt     <= '0;
      radd_q     <= '0;
      pair_valid <= 1'b0;
      pair_x     <= '0;
      pair_last  <= 1'b0;
    end else begin
      pair_valid <= accept;
      pair_last  <= accept && (rd_cnt == LAST_ADDR);
      if (accept) begin
        pair_x <= in_data;
        radd_q <= rd_cnt;
      end
      case (state)
        IDLE, RUN: begin
          if (accept) begin
            if (rd_cnt == LAST_ADDR) begin
              rd_cnt <= '0;
              state  <= DRAIN;
            end else begin
              rd_cnt <= rd_cnt + ADDR_W'(1);
              state  <= RUN;
            end
          end else if ((state == IDLE) && load_start) begin
            state <= load_finish ? IDLE : LOAD;
          end
        end
        DRAIN:   state <= IDLE;
        LOAD:    if (load_finish) state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

endmodule
